// File: rtl/dot_product_784_pkg.sv
// Shared widths, lane array types and the Q8.18 saturation helper for the
// 784-element dot-product neuron.
package dot_product_784_pkg;

   localparam int LANES  = 28;
   localparam int BEATS  = 28;
   localparam int PIX_W  = 10;
   localparam int WGT_W  = 19;
   localparam int OUT_W  = 26;
   localparam int ACC_W  = 40;
   localparam int PROD_W = WGT_W + PIX_W + 1;  // 30-bit Q12.18
   localparam int SUM_W  = PROD_W + 5;         // 35-bit, exact for 28 products
   localparam int CNT_W  = 5;                  // counts 0..BEATS+2

   typedef logic [LANES-1:0][PIX_W-1:0]  lane_pix_t;
   typedef logic [LANES-1:0][WGT_W-1:0]  lane_wgt_t;
   typedef logic [LANES-1:0][PROD_W-1:0] lane_prod_t;

   // Clamp a Q22.18 accumulator into Q8.18; in range when all bits above the
   // result sign bit agree with it.
   function automatic logic [OUT_W-1:0] sat_q8_18(input logic [ACC_W-1:0] a);
      logic [ACC_W-OUT_W:0] upper;
      upper = a[ACC_W-1:OUT_W-1];
      if ((&upper) || !(|upper))
         return a[OUT_W-1:0];
      else if (a[ACC_W-1])
         return {1'b1, {(OUT_W-1){1'b0}}};
      else
         return {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Stages S1+S2: 28 registered signed pixel*weight products, then one
// registered exact sum per beat.
module mac_adder_tree
   import dot_product_784_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  lane_pix_t               pix,
   input  lane_wgt_t               wgt,
   input  logic                    in_valid,
   output logic signed [SUM_W-1:0] beat_sum,
   output logic                    sum_valid
);

   lane_prod_t              prod;
   lane_prod_t              prod_next;
   logic                    prod_valid;
   logic signed [SUM_W-1:0] sum_next;

   always_comb begin
      prod_next = '0;
      for (int i = 0; i < LANES; i++) begin
         // pixel gets a zero sign bit so it multiplies as a non-negative value
         prod_next[i] = PROD_W'($signed(wgt[i])) * PROD_W'($signed({1'b0, pix[i]}));
      end
   end

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_next = sum_next + SUM_W'($signed(prod[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod       <= '0;
         prod_valid <= 1'b0;
         beat_sum   <= '0;
         sum_valid  <= 1'b0;
      end else begin
         prod_valid <= in_valid;
         sum_valid  <= prod_valid;
         if (in_valid)
            prod <= prod_next;
         if (prod_valid)
            beat_sum <= sum_next;
      end
   end

endmodule

// File: rtl/dot_product_784.sv
// 784-element fixed-point dot product: 28 lanes over 28 beats, exact
// accumulation, one saturated Q8.18 result held until the next reset.
module dot_product_784
   import dot_product_784_pkg::*;
(
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic [PIX_W-1:0] Pixel0,  Pixel1,  Pixel2,  Pixel3,  Pixel4,  Pixel5,  Pixel6,
   input  logic [PIX_W-1:0] Pixel7,  Pixel8,  Pixel9,  Pixel10, Pixel11, Pixel12, Pixel13,
   input  logic [PIX_W-1:0] Pixel14, Pixel15, Pixel16, Pixel17, Pixel18, Pixel19, Pixel20,
   input  logic [PIX_W-1:0] Pixel21, Pixel22, Pixel23, Pixel24, Pixel25, Pixel26, Pixel27,
   input  logic [WGT_W-1:0] Weight0,  Weight1,  Weight2,  Weight3,  Weight4,  Weight5,  Weight6,
   input  logic [WGT_W-1:0] Weight7,  Weight8,  Weight9,  Weight10, Weight11, Weight12, Weight13,
   input  logic [WGT_W-1:0] Weight14, Weight15, Weight16, Weight17, Weight18, Weight19, Weight20,
   input  logic [WGT_W-1:0] Weight21, Weight22, Weight23, Weight24, Weight25, Weight26, Weight27,
   output logic [OUT_W-1:0] value
);

   lane_pix_t               pix;
   lane_wgt_t               wgt;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    done;
   logic                    sample;
   logic signed [SUM_W-1:0] beat_sum;
   logic                    sum_valid;
   logic signed [ACC_W-1:0] acc;

   assign pix = {Pixel27, Pixel26, Pixel25, Pixel24, Pixel23, Pixel22, Pixel21,
                 Pixel20, Pixel19, Pixel18, Pixel17, Pixel16, Pixel15, Pixel14,
                 Pixel13, Pixel12, Pixel11, Pixel10, Pixel9,  Pixel8,  Pixel7,
                 Pixel6,  Pixel5,  Pixel4,  Pixel3,  Pixel2,  Pixel1,  Pixel0};
   assign wgt = {Weight27, Weight26, Weight25, Weight24, Weight23, Weight22, Weight21,
                 Weight20, Weight19, Weight18, Weight17, Weight16, Weight15, Weight14,
                 Weight13, Weight12, Weight11, Weight10, Weight9,  Weight8,  Weight7,
                 Weight6,  Weight5,  Weight4,  Weight3,  Weight2,  Weight1,  Weight0};

   // beat_cnt equals k while edge Ek is being taken
   assign sample = !done && (beat_cnt < CNT_W'(BEATS));

   mac_adder_tree u_tree (
      .clk       (clk),
      .reset     (GlobalReset),
      .pix       (pix),
      .wgt       (wgt),
      .in_valid  (sample),
      .beat_sum  (beat_sum),
      .sum_valid (sum_valid)
   );

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         beat_cnt <= '0;
         acc      <= '0;
         value    <= '0;
         done     <= 1'b0;
      end else if (!done) begin
         if (sum_valid)
            acc <= acc + ACC_W'(beat_sum);
         // last accumulate lands at E29, so the result is taken at E30
         if (beat_cnt == CNT_W'(BEATS + 2)) begin
            value <= sat_q8_18(acc);
            done  <= 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dot_product_784.sv
// Directed bench for dot_product_784: hand-computed results, value checked
// on every edge of each run, abort and post-done reset behaviour.
module tb_dot_product_784;

   logic        clk;
   logic        GlobalReset;
   logic [9:0]  pix [28];
   logic [18:0] wgt [28];
   logic [25:0] value;

   int n_checks;
   int n_fail;

   dot_product_784 dut (
      .clk(clk), .GlobalReset(GlobalReset),
      .Pixel0(pix[0]),   .Pixel1(pix[1]),   .Pixel2(pix[2]),   .Pixel3(pix[3]),
      .Pixel4(pix[4]),   .Pixel5(pix[5]),   .Pixel6(pix[6]),   .Pixel7(pix[7]),
      .Pixel8(pix[8]),   .Pixel9(pix[9]),   .Pixel10(pix[10]), .Pixel11(pix[11]),
      .Pixel12(pix[12]), .Pixel13(pix[13]), .Pixel14(pix[14]), .Pixel15(pix[15]),
      .Pixel16(pix[16]), .Pixel17(pix[17]), .Pixel18(pix[18]), .Pixel19(pix[19]),
      .Pixel20(pix[20]), .Pixel21(pix[21]), .Pixel22(pix[22]), .Pixel23(pix[23]),
      .Pixel24(pix[24]), .Pixel25(pix[25]), .Pixel26(pix[26]), .Pixel27(pix[27]),
      .Weight0(wgt[0]),   .Weight1(wgt[1]),   .Weight2(wgt[2]),   .Weight3(wgt[3]),
      .Weight4(wgt[4]),   .Weight5(wgt[5]),   .Weight6(wgt[6]),   .Weight7(wgt[7]),
      .Weight8(wgt[8]),   .Weight9(wgt[9]),   .Weight10(wgt[10]), .Weight11(wgt[11]),
      .Weight12(wgt[12]), .Weight13(wgt[13]), .Weight14(wgt[14]), .Weight15(wgt[15]),
      .Weight16(wgt[16]), .Weight17(wgt[17]), .Weight18(wgt[18]), .Weight19(wgt[19]),
      .Weight20(wgt[20]), .Weight21(wgt[21]), .Weight22(wgt[22]), .Weight23(wgt[23]),
      .Weight24(wgt[24]), .Weight25(wgt[25]), .Weight26(wgt[26]), .Weight27(wgt[27]),
      .value(value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // kind 1: w=0.125, pixel=index mod 2   kind 2: w=-1.0, pixel=1
   // kind 3: lane0 w=0x3FFFF, Pixel0=100 on beat 0 only   kind 6: w=1/16, pixel=3
   task automatic drive(input int kind, input int b);
      for (int l = 0; l < 28; l++) begin
         if (b >= 28) begin
            pix[l] = 10'($urandom_range(0, 1023));
            wgt[l] = 19'($urandom);
         end else begin
            case (kind)
               1: begin wgt[l] = 19'h08000; pix[l] = 10'((b * 28 + l) % 2); end
               2: begin wgt[l] = 19'h40000; pix[l] = 10'd1; end
               3: begin
                  wgt[l] = (l == 0) ? 19'h3FFFF : 19'h0;
                  pix[l] = (l == 0 && b == 0) ? 10'd100 : 10'd0;
               end
               default: begin wgt[l] = 19'h04000; pix[l] = 10'd3; end
            endcase
         end
      end
   endtask

   // Entered at a negedge with GlobalReset high; leaves at a negedge.
   task automatic run_dot(input int kind, input logic [25:0] exp_val,
                          input int abort_at, input int hold_cycles);
      GlobalReset = 1'b0;
      for (int b = 0; b <= 30; b++) begin
         drive(kind, b);
         if (b == abort_at) begin
            GlobalReset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("abort_clear", 32'(value), 32'h0);
            return;
         end
         @(posedge clk);
         @(negedge clk);
         if (b == 30) chk("final", 32'(value), 32'(exp_val));
         else         chk($sformatf("pre_E%0d", b), 32'(value), 32'h0);
      end
      for (int c = 0; c < hold_cycles; c++) begin
         drive(kind, 99);
         @(posedge clk);
         @(negedge clk);
         chk("hold", 32'(value), 32'(exp_val));
      end
   endtask

   task automatic reset_after_done();
      GlobalReset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_after_done", 32'(value), 32'h0);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      GlobalReset = 1'b1;
      for (int l = 0; l < 28; l++) begin
         pix[l] = 10'($urandom_range(0, 1023));
         wgt[l] = 19'($urandom);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_value", 32'(value), 32'h0);

      run_dot(1, 26'h0C40000, -1, 260);
      chk("int_part_49", 32'(value[25:18]), 32'd49);
      reset_after_done();

      run_dot(2, 26'h2000000, -1, 4);
      reset_after_done();

      run_dot(3, 26'h18FFF9C, -1, 4);
      reset_after_done();

      run_dot(1, 26'h0C40000, 15, 0);
      run_dot(1, 26'h0C40000, -1, 4);
      reset_after_done();

      run_dot(6, 26'h1FFFFFF, -1, 4);
      reset_after_done();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
